reg_file: RTL
=============

// Module: reg_file
// PURPOSE
// - Architectural register file with rename status for the Tomasulo core; 32 x 32-bit regs, each with busy flag + ROB tag.
// - Dispatch reads rs1/rs2 (value or producing ROB tag) and marks rd as renamed; ROB writes committed results back.
// - Branch-mispredict flush clears all rename state. Sits between decode/dispatch and RS/LSB, fed at commit by ROB.
// PARAMETERS
// - REG_NUM    32  architectural registers (x0 hardwired zero)
// - REG_IDX_W  5   register index width
// - DATA_W     32  register data width
// - ROB_IDX_W  4   ROB tag width (16-entry ROB)
// PORTS
// - clk           in   1          clock, all state on rising edge
// - rst           in   1          synchronous reset, active-high
// - rdy           in   1          global enable; low = all state frozen
// - rs1_idx       in   REG_IDX_W  source 1 index (dispatch)
// - rs1_value     out  DATA_W     source 1 value, valid when rs1_busy=0
// - rs1_busy      out  1          source 1 awaits ROB entry rs1_tag
// - rs1_tag       out  ROB_IDX_W  producing ROB entry of source 1
// - rs2_idx/rs2_value/rs2_busy/rs2_tag  same as rs1 for source 2
// - rename_en     in   1          dispatch allocates ROB entry writing rename_rd
// - rename_rd     in   REG_IDX_W  destination reg being renamed
// - rename_tag    in   ROB_IDX_W  ROB entry allocated
// - commit_en     in   1          ROB commits a reg-writing instruction
// - commit_rd     in   REG_IDX_W  committed destination
// - commit_tag    in   ROB_IDX_W  ROB entry being committed
// - commit_value  in   DATA_W     committed result
// - flush         in   1          mispredict (ROB jump_wrong): discard all renames
// BEHAVIOUR
// - Reset (rst=1 at edge, overrides rdy): all data=0, busy=0, tag=0; read outputs thus 0/0/0.
// - rdy=0 and rst=0: no state change; read outputs remain combinational on current state.
// - Reads: combinational, zero latency. idx=0 -> value 0, busy 0, tag 0 always.
// - Read bypass: if commit_en && commit_rd==idx!=0 && busy[idx] && tag[idx]==commit_tag
//   -> value=commit_value, busy=0 same cycle. Otherwise value/busy/tag straight from arrays.
// - Commit (edge, commit_en, commit_rd!=0): data[rd]<=commit_value always;
//   busy[rd]<=0 only if tag[rd]==commit_tag (younger rename still in flight otherwise).
// - Rename (edge, rename_en, rename_rd!=0, !flush): busy[rd]<=1, tag[rd]<=rename_tag.
// - Rename+commit same rd same edge: data written, rename wins -> busy=1, tag=rename_tag.
// - Flush (edge): busy cleared for all regs, tags untouched, rename ignored;
//   a simultaneous commit still writes data (committing instr is older than flush point).
// - Writes/renames to x0 ignored; x0 data stays 0.
// - Read of reg renamed in same cycle returns pre-rename state (dispatch handles rs==rd itself).
// - No handshakes; upstream guarantees at most one rename and one commit per cycle.
// STRUCTURE
// - Widths as macros in shared define.v: `REGINDEX, `DATALEN, `ROBINDEX (ROB tag).
// - One natural sub-module: reg_file_read_port (index + arrays + commit bus -> value/busy/tag
//   incl. x0 and bypass), instanced twice for rs1/rs2.
// - Top holds three arrays (data, busy, tag) and the commit/rename/flush update logic.
// TESTING
// - Reset then read rs1=5, rs2=0 -> value 0, busy 0, tag 0 on both.
// - Rename x5 tag 3; next cycle read x5 -> busy 1, tag 3; commit x5 tag 3 value 0xDEADBEEF
//   -> same-cycle read shows value 0xDEADBEEF busy 0; after edge busy 0, data held.
// - Rename x7 tag 2, then x7 tag 9; commit x7 tag 2 val 0x11 -> data 0x11, busy 1, tag 9 kept.
// - Same edge rename x4 tag 6 + commit x4 tag(old=1) val 0x22 -> data 0x22, busy 1, tag 6.
// - Rename x1..x3, then flush with commit x2 val 0x55 and rename x8 -> all busy 0, x2=0x55, x8 not busy.
// - Rename/commit x0 val 0xFF -> x0 reads 0 not busy; rdy=0 with rename x9 -> x9 unchanged;
//   rst mid-operation with busy regs -> all cleared next cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared widths and types for the architectural register file with rename status.
// Both the top and the read-port sub-module import this package.
package reg_file_pkg;

   localparam int REG_NUM   = 32;
   localparam int REG_IDX_W = 5;
   localparam int DATA_W    = 32;
   localparam int ROB_IDX_W = 4;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0]    data_t;
   typedef logic [ROB_IDX_W-1:0] rob_tag_t;

   typedef logic [REG_NUM-1:0][DATA_W-1:0]    data_array_t;
   typedef logic [REG_NUM-1:0][ROB_IDX_W-1:0] tag_array_t;
   typedef logic [REG_NUM-1:0]                busy_vec_t;

   // x0 is hardwired zero; it never holds data or rename state.
   function automatic logic is_arch_reg(input reg_idx_t idx);
      return idx != '0;
   endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One dispatch read port: looks up value/busy/tag for a source register,
// forcing x0 to zero and forwarding a same-cycle commit that resolves the rename.
module reg_file_read_port
   import reg_file_pkg::*;
(
   input  reg_idx_t    idx,
   input  data_array_t data,
   input  busy_vec_t   busy_vec,
   input  tag_array_t  tag_vec,
   input  logic        commit_en,
   input  reg_idx_t    commit_rd,
   input  rob_tag_t    commit_tag,
   input  data_t       commit_value,
   output data_t       value,
   output logic        busy,
   output rob_tag_t    tag
);

   logic commit_hit;

   // Forward only when the commit is from the producer this register still waits on.
   assign commit_hit = commit_en && (commit_rd == idx) && busy_vec[idx]
                       && (tag_vec[idx] == commit_tag);

   always_comb begin
      value = data[idx];
      busy  = busy_vec[idx];
      tag   = tag_vec[idx];
      if (!is_arch_reg(idx)) begin
         value = '0;
         busy  = 1'b0;
         tag   = '0;
      end else if (commit_hit) begin
         value = commit_value;
         busy  = 1'b0;
      end
   end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Dispatch reads two sources and renames a destination; the ROB writes back at commit.
module reg_file
   import reg_file_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     rdy,

   input  reg_idx_t rs1_idx,
   output data_t    rs1_value,
   output logic     rs1_busy,
   output rob_tag_t rs1_tag,

   input  reg_idx_t rs2_idx,
   output data_t    rs2_value,
   output logic     rs2_busy,
   output rob_tag_t rs2_tag,

   input  logic     rename_en,
   input  reg_idx_t rename_rd,
   input  rob_tag_t rename_tag,

   input  logic     commit_en,
   input  reg_idx_t commit_rd,
   input  rob_tag_t commit_tag,
   input  data_t    commit_value,

   input  logic     flush
);

   data_array_t data_q;
   busy_vec_t   busy_q;
   tag_array_t  tag_q;

   logic commit_wr;
   logic rename_wr;

   assign commit_wr = commit_en && is_arch_reg(commit_rd);
   assign rename_wr = rename_en && is_arch_reg(rename_rd) && !flush;

   // Rename is applied after commit so a same-register rename in the same cycle wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         busy_q <= '0;
         tag_q  <= '0;
      end else if (rdy) begin
         if (commit_wr) begin
            data_q[commit_rd] <= commit_value;
            if (tag_q[commit_rd] == commit_tag)
               busy_q[commit_rd] <= 1'b0;
         end
         if (flush)
            busy_q <= '0;
         else if (rename_wr) begin
            busy_q[rename_rd] <= 1'b1;
            tag_q[rename_rd]  <= rename_tag;
         end
      end
   end

   reg_file_read_port u_rs1 (
      .idx          (rs1_idx),
      .data         (data_q),
      .busy_vec     (busy_q),
      .tag_vec      (tag_q),
      .commit_en    (commit_en),
      .commit_rd    (commit_rd),
      .commit_tag   (commit_tag),
      .commit_value (commit_value),
      .value        (rs1_value),
      .busy         (rs1_busy),
      .tag          (rs1_tag)
   );

   reg_file_read_port u_rs2 (
      .idx          (rs2_idx),
      .data         (data_q),
      .busy_vec     (busy_q),
      .tag_vec      (tag_q),
      .commit_en    (commit_en),
      .commit_rd    (commit_rd),
      .commit_tag   (commit_tag),
      .commit_value (commit_value),
      .value        (rs2_value),
      .busy         (rs2_busy),
      .tag          (rs2_tag)
   );

endmodule
